multiplicacao_num_matriz_seq: RTL

Sequential, parametrised scalar-by-matrix multiplier. It is the successor to the combinational scalar multiply in the matrix coprocessor datapath. It accepts a square matrix of signed elements of 1..MAX_DIM per side plus one signed scalar, and processes LANES elements per clock. It supports wrap or saturating result mode and reports done, overflow and invalid-size status through a start/busy/done handshake.

---
 rtl/multiplicacao_num_matriz_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/multiplicacao_num_matriz_seq.sv
// ---------------------------------------------------------------------------
// multiplicacao_num_matriz_seq
//
// Sequential scalar-by-matrix multiplier. A square matrix of signed DATA_W
// elements (side 1..MAX_DIM, row-major, flat bus) is multiplied by a signed
// scalar, LANES elements per clock. Each result is either wrapped to DATA_W
// bits or saturated to the signed DATA_W range. Handshake: start (sampled in
// IDLE), busy (during compute), done (one-cycle pulse, results valid).
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         operation request, only honoured in IDLE
//   matriz_A      input matrix, element i at [i*DATA_W +: DATA_W]
//   num_inteiro   signed scalar
//   matrix_dim    matrix side, valid 1..MAX_DIM
//   sat_mode      0 = wrap, 1 = saturate
//   busy          high while elements are being computed
//   done          one-cycle pulse when results are published
//   nova_matriz_A result matrix, same layout as matriz_A
//   overflow_flag some active element's product did not fit in DATA_W
//   erro          last request carried an invalid matrix_dim
// ---------------------------------------------------------------------------
module multiplicacao_num_matriz_seq #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_DIM = 5,
    parameter int unsigned LANES   = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   matriz_A,
    input  logic [DATA_W-1:0]                   num_inteiro,
    input  logic [$clog2(MAX_DIM+1)-1:0]        matrix_dim,
    input  logic                                sat_mode,
    output logic                                busy,
    output logic                                done,
    output logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   nova_matriz_A,
    output logic                                overflow_flag,
    output logic                                erro
);

    localparam int unsigned NUM_EL = MAX_DIM * MAX_DIM;
    localparam int unsigned BUS_W  = NUM_EL * DATA_W;
    localparam int unsigned DIM_W  = $clog2(MAX_DIM + 1);
    // Index must hold N-1+LANES without wrapping.
    localparam int unsigned IDX_W  = $clog2(NUM_EL + LANES + 1);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCompute, StFinish} state_e;

    state_e              state_q, state_d;
    logic [BUS_W-1:0]    a_q, a_d;
    logic [DATA_W-1:0]   scal_q, scal_d;
    logic                sat_q, sat_d;
    logic [IDX_W-1:0]    n_q, n_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BUS_W-1:0]    work_res_q, work_res_d;
    logic                work_ovf_q, work_ovf_d;
    logic [BUS_W-1:0]    res_q, res_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                dim_ok;
    logic [IDX_W-1:0]    dim_ext;
    logic [IDX_W-1:0]    idx_next;

    logic [DATA_W-1:0]   el_wrap [NUM_EL];
    logic [DATA_W-1:0]   el_sat  [NUM_EL];
    logic [NUM_EL-1:0]   el_ovf;
    logic [NUM_EL-1:0]   el_act;

    assign dim_ok   = (matrix_dim != '0) && (matrix_dim <= DIM_W'(MAX_DIM));
    assign dim_ext  = IDX_W'(matrix_dim);
    assign idx_next = idx_q + IDX_W'(LANES);

    // One multiplier per element; only the lanes selected by idx_q are used.
    for (genvar k = 0; k < NUM_EL; k++) begin : g_el
        logic [2*DATA_W-1:0] a_ext;
        logic [2*DATA_W-1:0] s_ext;
        logic [2*DATA_W-1:0] prod;
        logic                fits;

        assign a_ext = {{DATA_W{a_q[k*DATA_W+DATA_W-1]}}, a_q[k*DATA_W +: DATA_W]};
        assign s_ext = {{DATA_W{scal_q[DATA_W-1]}}, scal_q};
        // Low 2*DATA_W bits of the product are the exact signed product.
        assign prod  = a_ext * s_ext;
        // Fits in DATA_W iff the top DATA_W+1 bits are all equal.
        assign fits  = (&prod[2*DATA_W-1:DATA_W-1]) | ~(|prod[2*DATA_W-1:DATA_W-1]);

        assign el_ovf[k]  = ~fits;
        assign el_wrap[k] = prod[DATA_W-1:0];
        assign el_sat[k]  = fits ? prod[DATA_W-1:0] : (prod[2*DATA_W-1] ? SAT_MIN : SAT_MAX);
        assign el_act[k]  = (IDX_W'(k) >= idx_q) && (IDX_W'(k) < idx_next) &&
                            (IDX_W'(k) < n_q);
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        scal_d     = scal_q;
        sat_d      = sat_q;
        n_d        = n_q;
        idx_d      = idx_q;
        work_res_d = work_res_q;
        work_ovf_d = work_ovf_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d        = matriz_A;
                    scal_d     = num_inteiro;
                    sat_d      = sat_mode;
                    n_d        = dim_ext * dim_ext;
                    idx_d      = '0;
                    work_res_d = '0;
                    work_ovf_d = 1'b0;
                    if (dim_ok) begin
                        state_d = StCompute;
                        busy_d  = 1'b1;
                    end else begin
                        // Invalid size publishes straight away with a zero result.
                        state_d = StFinish;
                        done_d  = 1'b1;
                        res_d   = '0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end

            StCompute: begin
                for (int k = 0; k < NUM_EL; k++) begin
                    if (el_act[k]) begin
                        work_res_d[k*DATA_W +: DATA_W] = sat_q ? el_sat[k] : el_wrap[k];
                        work_ovf_d = work_ovf_d | el_ovf[k];
                    end
                end
                idx_d = idx_next;
                if (idx_next >= n_q) begin
                    // Publish on the same edge that enters FINISH so done and
                    // the results appear together.
                    state_d = StFinish;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    res_d   = work_res_d;
                    ovf_d   = work_ovf_d;
                    err_d   = 1'b0;
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            scal_q     <= '0;
            sat_q      <= 1'b0;
            n_q        <= '0;
            idx_q      <= '0;
            work_res_q <= '0;
            work_ovf_q <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            scal_q     <= scal_d;
            sat_q      <= sat_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            work_res_q <= work_res_d;
            work_ovf_q <= work_ovf_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign nova_matriz_A = res_q;
    assign overflow_flag = ovf_q;
    assign erro          = err_q;

endmodule
